// File: rtl/clk_mux_cfg_pkg.sv
// Shared types and constants for the clock-mux configuration loader.
// Word length depends on CLK_MUX_CFG_PARITY_EN (7 bits with odd parity, else 6).
package clk_mux_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK,
    SETTLE
  } state_t;

  localparam int unsigned CFG_W        = 6;
  localparam int unsigned POL          = 5;
  localparam int unsigned EN           = 4;
  localparam int unsigned SEL_MSB      = 3;
  localparam int unsigned MAX_SEL      = 11;
  localparam int unsigned BIT_CNT_W    = 3;
  localparam int unsigned SETTLE_CNT_W = 4;

`ifdef CLK_MUX_CFG_PARITY_EN
  localparam int unsigned WORD_LEN = CFG_W + 1;
`else
  localparam int unsigned WORD_LEN = CFG_W;
`endif

  // True when the select index addresses one of the mux inputs.
  function automatic logic sel_in_range(input logic [SEL_MSB:0] sel);
    return sel <= (SEL_MSB + 1)'(MAX_SEL);
  endfunction

endpackage

// File: rtl/clk_mux_cfg_loader.sv
// Serial configuration loader that commits a validated select word to the clock mux.
// Optional odd-parity check over the serial word is enabled by CLK_MUX_CFG_PARITY_EN.
module clk_mux_cfg_loader
  import clk_mux_cfg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_start,
  input  logic       cfg_valid,
  input  logic       cfg_sdi,
  output logic [5:0] cbit,
  output logic [5:0] cbitb,
  output logic       prog,
  output logic       cenb,
  output logic       cfg_done,
  output logic       cfg_err
);

  state_t                    state;
  logic [WORD_LEN-1:0]       shadow;
  logic [BIT_CNT_W-1:0]      bit_cnt;
  logic [SETTLE_CNT_W-1:0]   settle_cnt;
  logic [CFG_W-1:0]          cfg_word;
  logic                      word_ok;

  // Config bits occupy the top of the shadow; a parity bit, if present, sits in the LSB.
  assign cfg_word = shadow[WORD_LEN-1 -: CFG_W];

`ifdef CLK_MUX_CFG_PARITY_EN
  assign word_ok = sel_in_range(cfg_word[SEL_MSB:0]) && (^shadow);
`else
  assign word_ok = sel_in_range(cfg_word[SEL_MSB:0]);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shadow     <= '0;
      bit_cnt    <= '0;
      settle_cnt <= '0;
      cbit       <= 6'h00;
      cbitb      <= 6'h3F;
      prog       <= 1'b0;
      cenb       <= 1'b1;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state   <= SHIFT;
            prog    <= 1'b1;
            cenb    <= 1'b1;
            shadow  <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (cfg_valid) begin
            shadow <= {shadow[WORD_LEN-2:0], cfg_sdi};
            if (bit_cnt == BIT_CNT_W'(WORD_LEN - 1)) begin
              bit_cnt <= '0;
              state   <= CHECK;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        CHECK: begin
          if (word_ok) begin
            cbit       <= cfg_word;
            cbitb      <= ~cfg_word;
            settle_cnt <= SETTLE_CNT_W'(SETTLE_CYCLES - 1);
            state      <= SETTLE;
          end else begin
            // Rejected word: the previously committed select stays in force.
            cfg_err <= 1'b1;
            prog    <= 1'b0;
            cenb    <= ~cbit[EN];
            state   <= IDLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            prog     <= 1'b0;
            cenb     <= ~cbit[EN];
            cfg_done <= 1'b1;
            state    <= IDLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_mux_cfg_loader.sv
// Self-checking bench for clk_mux_cfg_loader using an expected-result scoreboard.
module tb_clk_mux_cfg_loader;
  import clk_mux_cfg_pkg::*;

  localparam int unsigned S = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_sdi = 1'b0;
  logic [5:0] cbit;
  logic [5:0] cbitb;
  logic       prog;
  logic       cenb;
  logic       cfg_done;
  logic       cfg_err;

  typedef struct packed {
    logic       err;
    logic [5:0] cbit;
    logic       cenb;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [5:0] cbit_m = 6'h00;

  clk_mux_cfg_loader #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_sdi   (cfg_sdi),
    .cbit      (cbit),
    .cbitb     (cbitb),
    .prog      (prog),
    .cenb      (cenb),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] make_word(input logic [5:0] cfg, input logic bad_par);
`ifdef CLK_MUX_CFG_PARITY_EN
    return {cfg, (~^cfg) ^ bad_par};
`else
    return {1'b0, cfg ^ {6{bad_par & 1'b0}}};
`endif
  endfunction

  task automatic check_reset_vals(input string name);
    checks++;
    if (cbit !== 6'h00 || cbitb !== 6'h3F || prog !== 1'b0 || cenb !== 1'b1 ||
        cfg_done !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: cbit=%h cbitb=%h prog=%b cenb=%b done=%b err=%b, want 00 3f 0 1 0 0",
               name, cbit, cbitb, prog, cenb, cfg_done, cfg_err);
    end
  endtask

  // Drives one full load; expectation is pushed up front and popped on done/err.
  task automatic do_load(input string name, input logic [5:0] cfg, input logic bad_par,
                         input bit stall, input bit poke);
    logic [6:0] w;
    exp_t       e;
    exp_t       got;
    int         acc;
    int         cyc;
    int         n;
    bit         ok;
    w  = make_word(cfg, bad_par);
    ok = (cfg[3:0] <= 4'd11) && !bad_par;
    if (ok) cbit_m = cfg;
    e.err  = !ok;
    e.cbit = cbit_m;
    e.cenb = ~cbit_m[4];
    sb.push_back(e);

    cfg_start = 1'b1;
    step;
    cfg_start = 1'b0;
    checks++;
    if (prog !== 1'b1 || cenb !== 1'b1) begin
      errors++;
      $display("FAIL %s_start: prog=%b cenb=%b, want 1 1", name, prog, cenb);
    end

    acc = 0;
    cyc = 0;
    while (acc < int'(WORD_LEN) && cyc < 100) begin
      if (stall && (cyc % 3) != 0) begin
        cfg_valid = 1'b0;
        cfg_sdi   = 1'b1;
        cfg_start = poke;
      end else begin
        cfg_valid = 1'b1;
        cfg_sdi   = w[int'(WORD_LEN) - 1 - acc];
        acc++;
      end
      step;
      cyc++;
      cfg_start = 1'b0;
    end
    cfg_valid = 1'b0;
    cfg_sdi   = 1'b0;

    n = 0;
    while (n < int'(S) + 3) begin
      step;
      n++;
      if (n == 1 && !e.err) begin
        checks++;
        if (cbit !== cfg || cbitb !== ~cfg || prog !== 1'b1 || cenb !== 1'b1 || cfg_done !== 1'b0) begin
          errors++;
          $display("FAIL %s_commit: cbit=%h cbitb=%h prog=%b cenb=%b done=%b, want %h %h 1 1 0",
                   name, cbit, cbitb, prog, cenb, cfg_done, cfg, ~cfg);
        end
      end
      if (cfg_done === 1'b1 || cfg_err === 1'b1) break;
    end

    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: queue empty", name);
    end else begin
      got = sb.pop_front();
      if (!(cfg_done === 1'b1 || cfg_err === 1'b1)) begin
        errors++;
        $display("FAIL %s_timeout: no done/err within %0d cycles", name, n);
      end else if (cfg_err !== got.err || cfg_done !== ~got.err || cbit !== got.cbit ||
                   cbitb !== ~got.cbit || cenb !== got.cenb || prog !== 1'b0 ||
                   n != (got.err ? 1 : int'(S) + 1)) begin
        errors++;
        $display("FAIL %s_result: err=%b done=%b cbit=%h cbitb=%h cenb=%b prog=%b lat=%0d, want err=%b cbit=%h cenb=%b prog=0 lat=%0d",
                 name, cfg_err, cfg_done, cbit, cbitb, cenb, prog, n,
                 got.err, got.cbit, got.cenb, got.err ? 1 : int'(S) + 1);
      end
    end

    step;
    checks++;
    if (cfg_done !== 1'b0 || cfg_err !== 1'b0 || prog !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: done=%b err=%b prog=%b, want 0 0 0", name, cfg_done, cfg_err, prog);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    check_reset_vals("reset");
    rst = 1'b0;
    step;
    check_reset_vals("reset_release");
  endtask

  task automatic test_idle_ignore;
    cfg_valid = 1'b1;
    cfg_sdi   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      checks++;
      if (prog !== 1'b0 || cbit !== cbit_m) begin
        errors++;
        $display("FAIL idle_ignore: prog=%b cbit=%h, want 0 %h", prog, cbit, cbit_m);
      end
    end
    cfg_valid = 1'b0;
    cfg_sdi   = 1'b0;
  endtask

  task automatic test_valid_load;
    do_load("valid", 6'b110101, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_invalid_sel;
    do_load("invalid", 6'b111100, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_disable;
    do_load("disable", 6'b100011, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stall;
    do_load("stall", 6'b110101, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_shift;
    logic [5:0] w;
    w = 6'h35;
    cfg_start = 1'b1;
    step;
    cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1;
      cfg_sdi   = w[5 - i];
      step;
    end
    cfg_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("reset_mid_shift");
    step;
    rst    = 1'b0;
    cbit_m = 6'h00;
    step;
    do_load("after_reset", 6'h35, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef CLK_MUX_CFG_PARITY_EN
  task automatic test_parity;
    do_load("parity_bad", 6'h35, 1'b1, 1'b0, 1'b0);
    do_load("parity_good", 6'h35, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_async_reset;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals("async_reset");
    step;
    rst    = 1'b0;
    cbit_m = 6'h00;
    sb.delete();
    step;
  endtask

  initial begin
    test_reset;
    test_idle_ignore;
    test_valid_load;
    test_invalid_sel;
    test_disable;
    test_stall;
    test_reset_mid_shift;
`ifdef CLK_MUX_CFG_PARITY_EN
    test_parity;
`endif
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
